// File: rtl/turbo_perm_pkg.sv
// Shared mode encodings, frame-length width and lane-index helper for turbo_lane_perm.
// Table mode support in the top is built only when TURBO_LANE_PERM_TABLE_EN is defined.
package turbo_perm_pkg;

    typedef enum logic [1:0] {
        PERM_IDENT  = 2'd0,
        PERM_BITREV = 2'd1,
        PERM_REV    = 2'd2,
        PERM_TABLE  = 2'd3
    } perm_mode_e;

    localparam int FRAME_LEN_W = 16;
    localparam int MAX_LW      = 4;

    // Bit-reverse the low lw bits of idx: full-width reverse, then drop the unused low bits.
    function automatic logic [MAX_LW-1:0] bitrev(input logic [MAX_LW-1:0] idx, input int lw);
        logic [MAX_LW-1:0] rev;
        for (int i = 0; i < MAX_LW; i++) begin
            rev[MAX_LW-1-i] = idx[i];
        end
        return rev >> (MAX_LW - lw);
    endfunction

endpackage

// File: rtl/turbo_skid_buf.sv
// Two-entry output/skid register pair: in_ready depends only on skid occupancy.
module turbo_skid_buf #(
    parameter int PW = 137
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data
);

    logic          out_valid_q, out_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic [PW-1:0] out_data_q, out_data_d;
    logic [PW-1:0] skid_data_q, skid_data_d;
    logic          accept_s;

    assign in_ready  = !skid_valid_q;
    assign accept_s  = in_valid && !skid_valid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Output slot refills from skid first, otherwise from the input; a stalled output diverts to skid.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept_s) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_data_q   <= {PW{1'b0}};
            skid_data_q  <= {PW{1'b0}};
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_data_q   <= out_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/turbo_lane_perm.sv
// N-lane permutation stage with frame tracking behind a two-entry skid buffer.
// Define TURBO_LANE_PERM_TABLE_EN to build the programmable lane map (cfg_* ports, mode 3).
module turbo_lane_perm
    import turbo_perm_pkg::*;
#(
    parameter  int LANES = 4,
    parameter  int W     = 30,
    localparam int LW    = $clog2(LANES)
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef TURBO_LANE_PERM_TABLE_EN
    input  logic                   cfg_we,
    input  logic [LW-1:0]          cfg_lane,
    input  logic [LW-1:0]          cfg_src,
`endif
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*W-1:0]     in_data,
    input  logic                   in_last,
    input  logic [1:0]             mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*W-1:0]     out_data,
    output logic                   out_last,
    output logic [FRAME_LEN_W-1:0] out_len
);

    localparam int DW = LANES * W;
    localparam int PW = DW + 1 + FRAME_LEN_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FRAME = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [FRAME_LEN_W-1:0] cnt_q, cnt_d;
    logic [1:0]             eff_mode_s;
    logic [FRAME_LEN_W-1:0] beat_len_s;
    logic [DW-1:0]          perm_data_s;
    logic                   accept_s;

    assign accept_s = in_valid && in_ready;

`ifdef TURBO_LANE_PERM_TABLE_EN
    logic [LW-1:0] shadow_q [LANES];
    logic [LW-1:0] active_q [LANES];

    // Shadow takes cfg writes; active snapshots the pre-write shadow at frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LANES; i++) begin
                shadow_q[i] <= LW'(i);
                active_q[i] <= LW'(i);
            end
        end else begin
            if (accept_s && (state_q == ST_IDLE)) begin
                for (int i = 0; i < LANES; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            if (cfg_we) begin
                shadow_q[cfg_lane] <= cfg_src;
            end
        end
    end
`endif

    // The first beat of a frame uses the live mode input and restarts the length at one.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            eff_mode_s = mode;
            beat_len_s = 16'd1;
        end else begin
            eff_mode_s = mode_q;
            beat_len_s = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        end
        if (accept_s) begin
            mode_d  = eff_mode_s;
            cnt_d   = beat_len_s;
            state_d = in_last ? ST_IDLE : ST_FRAME;
        end else begin
            state_d = state_q;
        end
    end

    // Output lane d takes input lane src(d).
    always_comb begin : perm_mux
        logic [LW-1:0] src;
        perm_data_s = {DW{1'b0}};
        for (int d = 0; d < LANES; d++) begin
            src = LW'(d);
            case (eff_mode_s)
                PERM_BITREV: src = LW'(bitrev(MAX_LW'(d), LW));
                PERM_REV:    src = LW'(LANES - 1 - d);
`ifdef TURBO_LANE_PERM_TABLE_EN
                PERM_TABLE:  src = (state_q == ST_IDLE) ? shadow_q[d] : active_q[d];
`endif
                default:     src = LW'(d);
            endcase
            perm_data_s[d*W +: W] = in_data[src*W +: W];
        end
    end

    // Frame state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mode_q  <= 2'd0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    turbo_skid_buf #(
        .PW (PW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({perm_data_s, in_last, beat_len_s}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  ({out_data, out_last, out_len})
    );

endmodule

// File: tb/tb_turbo_lane_perm.sv
// Randomised self-checking bench for turbo_lane_perm against a queue-based frame model.
`timescale 1ns/1ps
module tb_turbo_lane_perm;

    localparam int LANES = 4;
    localparam int W     = 30;
    localparam int LW    = 2;
    localparam int DW    = LANES * W;
    localparam int PW    = DW + 17;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cfg_we = 1'b0;
    logic [LW-1:0]     cfg_lane = '0;
    logic [LW-1:0]     cfg_src = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     in_data = '0;
    logic              in_last = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic [15:0]       out_len;

    logic [PW-1:0] exp_q[$];
    bit            m_in_frame;
    logic [1:0]    m_mode;
    int            m_len;
    int            m_shadow[LANES];
    int            m_active[LANES];
    int            n_cmp = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    turbo_lane_perm #(.LANES(LANES), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef TURBO_LANE_PERM_TABLE_EN
        .cfg_we    (cfg_we),
        .cfg_lane  (cfg_lane),
        .cfg_src   (cfg_src),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_len   (out_len)
    );

    function automatic logic [DW-1:0] permute(input logic [DW-1:0] din, input logic [1:0] md);
        logic [DW-1:0] r;
        int s;
        r = '0;
        for (int d = 0; d < LANES; d++) begin
            case (md)
                2'd1: begin
                    s = 0;
                    for (int b = 0; b < LW; b++) begin
                        if (((d >> b) & 1) == 1) s += (1 << (LW - 1 - b));
                    end
                end
                2'd2: s = LANES - 1 - d;
`ifdef TURBO_LANE_PERM_TABLE_EN
                2'd3: s = m_active[d];
`endif
                default: s = d;
            endcase
            r[d*W +: W] = din[s*W +: W];
        end
        return r;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_in_frame = 1'b0;
        m_mode = 2'd0;
        m_len = 0;
        for (int i = 0; i < LANES; i++) begin
            m_shadow[i] = i;
            m_active[i] = i;
        end
    endtask

    // Advance model by one clock using the currently driven inputs, then step the DUT.
    task automatic tick();
        bit acc, drn;
        logic [DW-1:0] pd;
        pd  = '0;
        drn = (exp_q.size() > 0) && out_ready;
        acc = in_valid && (exp_q.size() < 2);
        if (acc) begin
            if (!m_in_frame) begin
                m_mode = mode;
                m_active = m_shadow;
                m_len = 1;
            end else if (m_len < 65535) begin
                m_len++;
            end
            pd = permute(in_data, m_mode);
            m_in_frame = !in_last;
        end
`ifdef TURBO_LANE_PERM_TABLE_EN
        if (cfg_we) m_shadow[cfg_lane] = int'(cfg_src);
`endif
        if (drn) void'(exp_q.pop_front());
        if (acc) exp_q.push_back({pd, in_last, 16'(m_len)});
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic last, input logic [1:0] md, input logic ordy);
        in_valid  = v;
        in_last   = last;
        mode      = md;
        out_ready = ordy;
        for (int k = 0; k < LANES; k++) in_data[k*W +: W] = W'($urandom);
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if ({out_data, out_last, out_len} !== {PW{1'b0}}) begin n_err++; $display("FAIL reset_outputs got %h want 0", {out_data, out_last, out_len}); end
        model_reset();
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_bitrev_single();
        drive(1'b1, 1'b1, 2'd1, 1'b1);
        in_data = {30'h4, 30'h3, 30'h2, 30'h1};
        tick();
        in_valid = 1'b0;
        n_cmp++; if ({out_valid, out_data, out_last, out_len} !== {1'b1, 30'h4, 30'h2, 30'h3, 30'h1, 1'b1, 16'd1})
            begin n_err++; $display("FAIL bitrev_single got %b %h %b %0d want 1 {4,2,3,1} 1 1", out_valid, out_data, out_last, out_len); end
        n_cmp++; if (exp_q.size() != 1 || {out_data, out_last, out_len} !== exp_q[0]) begin n_err++; $display("FAIL bitrev_model got %h", {out_data, out_last, out_len}); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bitrev_drain got %b want 0", out_valid); end
    endtask

    task automatic test_reverse_frame();
        for (int i = 0; i < 4; i++) begin
            drive(i < 3, i == 2, 2'd2, 1'b1);
            in_data = {30'h4, 30'h3, 30'h2, 30'h1};
            tick();
            n_cmp++; if (out_valid !== (i < 3)) begin n_err++; $display("FAIL rev_valid beat %0d got %b want %b", i, out_valid, i < 3); end
            if (i < 3) begin
                n_cmp++; if ({out_data, out_last} !== {30'h1, 30'h2, 30'h3, 30'h4, i == 2})
                    begin n_err++; $display("FAIL rev_data beat %0d got %h %b", i, out_data, out_last); end
                n_cmp++; if (i == 2 && out_len !== 16'd3) begin n_err++; $display("FAIL rev_len got %0d want 3", out_len); end
            end
        end
    endtask

    task automatic test_backpressure();
        int sent;
        bit acc;
        sent = 0;
        drive(1'b1, 1'b0, 2'd0, 1'b0);
        for (int c = 0; c < 14; c++) begin
            out_ready = (c >= 3);
            in_valid  = (sent < 6);
            in_last   = (sent == 5);
            acc = in_valid && (exp_q.size() < 2);
            tick();
            if (acc) begin
                sent++;
                for (int k = 0; k < LANES; k++) in_data[k*W +: W] = W'($urandom);
            end
            n_cmp++; if (out_valid !== (exp_q.size() > 0)) begin n_err++; $display("FAIL bp_valid cyc %0d got %b want %b", c, out_valid, exp_q.size() > 0); end
            n_cmp++; if (in_ready !== (exp_q.size() < 2)) begin n_err++; $display("FAIL bp_ready cyc %0d got %b want %b", c, in_ready, exp_q.size() < 2); end
            if (exp_q.size() > 0) begin
                n_cmp++; if ({out_data, out_last, out_len} !== exp_q[0]) begin n_err++; $display("FAIL bp_data cyc %0d got %h want %h", c, {out_data, out_last, out_len}, exp_q[0]); end
            end
            if (c == 2) begin
                n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full got %b want 0", in_ready); end
            end
        end
        n_cmp++; if (sent != 6) begin n_err++; $display("FAIL bp_sent got %0d want 6", sent); end
    endtask

    task automatic test_mode_change();
        logic [DW-1:0] sent [6];
        for (int i = 0; i < 7; i++) begin
            drive(i < 6, (i == 3) || (i == 5), (i == 0) ? 2'd0 : 2'd2, 1'b1);
            if (i < 6) sent[i] = in_data;
            tick();
            n_cmp++; if (out_valid !== (i < 6)) begin n_err++; $display("FAIL modechg_valid beat %0d got %b", i, out_valid); end
            if (i < 4) begin
                n_cmp++; if (out_data !== sent[i]) begin n_err++; $display("FAIL modechg_ident beat %0d got %h want %h", i, out_data, sent[i]); end
            end else if (i < 6) begin
                n_cmp++; if (out_data !== {sent[i][29:0], sent[i][59:30], sent[i][89:60], sent[i][119:90]})
                    begin n_err++; $display("FAIL modechg_rev beat %0d got %h", i, out_data); end
            end
        end
    endtask

`ifdef TURBO_LANE_PERM_TABLE_EN
    task automatic test_table();
        int map1[4] = '{3, 3, 0, 1};
        int map2[4] = '{2, 1, 1, 0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 2'd3, 1'b1);
            cfg_we = 1'b1; cfg_lane = LW'(i); cfg_src = LW'(map1[i]);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            drive(i != 4 && i < 7, (i == 3) || (i == 6), (i == 4) ? 2'd0 : 2'd3, 1'b1);
            in_data = {30'h4, 30'h3, 30'h2, 30'h1};
            cfg_we = (i >= 1 && i <= 4) || i == 5;
            cfg_lane = (i == 5) ? 2'd0 : LW'(i - 1);
            cfg_src  = (i == 5) ? 2'd3 : LW'(map2[(i - 1) & 3]);
            tick();
            n_cmp++; if (out_valid !== (exp_q.size() > 0)) begin n_err++; $display("FAIL tbl_valid step %0d got %b", i, out_valid); end
            if (exp_q.size() > 0) begin
                n_cmp++; if ({out_data, out_last, out_len} !== exp_q[0]) begin n_err++; $display("FAIL tbl_data step %0d got %h want %h", i, {out_data, out_last, out_len}, exp_q[0]); end
            end
            if (i <= 3) begin
                n_cmp++; if (out_data !== {30'h2, 30'h1, 30'h4, 30'h4}) begin n_err++; $display("FAIL tbl_map1 step %0d got %h", i, out_data); end
            end else if (i == 5 || i == 6) begin
                n_cmp++; if (out_data !== {30'h1, 30'h2, 30'h2, 30'h3}) begin n_err++; $display("FAIL tbl_map2 step %0d got %h", i, out_data); end
            end
        end
        cfg_we = 1'b0;
    endtask
`else
    task automatic test_table();
        drive(1'b1, 1'b1, 2'd3, 1'b1);
        in_data = {30'h4, 30'h3, 30'h2, 30'h1};
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_data !== {30'h4, 30'h3, 30'h2, 30'h1}) begin n_err++; $display("FAIL mode3_ident got %h", out_data); end
        tick();
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom % 4) != 0, ($urandom % 4) == 0, 2'($urandom), ($urandom % 3) != 0);
`ifdef TURBO_LANE_PERM_TABLE_EN
            cfg_we = ($urandom % 5) == 0; cfg_lane = LW'($urandom); cfg_src = LW'($urandom);
`endif
            tick();
            n_cmp++; if (out_valid !== (exp_q.size() > 0)) begin n_err++; $display("FAIL rnd_valid cyc %0d got %b", c, out_valid); end
            n_cmp++; if (in_ready !== (exp_q.size() < 2)) begin n_err++; $display("FAIL rnd_ready cyc %0d got %b", c, in_ready); end
            if (exp_q.size() > 0) begin
                n_cmp++; if ({out_data, out_last, out_len} !== exp_q[0]) begin n_err++; $display("FAIL rnd_data cyc %0d got %h want %h", c, {out_data, out_last, out_len}, exp_q[0]); end
            end
        end
        cfg_we = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 2'd0, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_err++; $display("FAIL arst_prefill got rdy %b vld %b want 0 1", in_ready, out_valid); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin n_err++; $display("FAIL arst_out got %b %b want 0 0", out_valid, out_last); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL arst_ready got %b want 1", in_ready); end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(i < 2, i == 1, 2'd0, 1'b1);
            tick();
            if (i < 2) begin
                n_cmp++; if ({out_data, out_last, out_len} !== exp_q[0]) begin n_err++; $display("FAIL arst_data beat %0d got %h want %h", i, {out_data, out_last, out_len}, exp_q[0]); end
                n_cmp++; if (out_len !== 16'(i + 1)) begin n_err++; $display("FAIL arst_len beat %0d got %0d want %0d", i, out_len, i + 1); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bitrev_single();
        test_reverse_frame();
        test_backpressure();
        test_mode_change();
        test_table();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/turbo_lane_perm.md
# turbo_lane_perm

Parametrised N-lane permutation stage for the radix-N parallel turbo decoder datapath: each beat carries LANES extrinsic words of W bits. The stage reorders them per a per-frame mode and registers the result behind a valid/ready handshake with a two-entry skid buffer. It replaces the fixed 4-lane middle-swap register stage between the two SISO halves, and adds frame tracking and a programmable lane map.

## Interface
- LANES, 4, lane count; power of 2, 2..16
- W, 30, bits per lane word
- LW, $clog2(LANES), lane index width (derived, not overridden)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- in_data  in  LANES*W  lane k at bits [k*W +: W]
- in_last  in  1  final beat of frame
- mode  in  2  0 identity, 1 bit-reverse, 2 reverse, 3 table; sampled at frame start
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  LANES*W  permuted beat
- out_last  out  1  final beat of frame
- out_len  out  16  beats in frame, valid when out_valid && out_last
- cfg_we  in  1  table write strobe (macro only)
- cfg_lane  in  LW  destination lane (macro only)
- cfg_src  in  LW  source lane for that destination (macro only)

## Operation
- Output lane d = input lane src(d): mode 0 src=d; mode 1 src=bitrev(d) over LW bits (LANES=4 gives 0,2,1,3); mode 2 src=LANES-1-d; mode 3 src=active_table[d].
- FSM IDLE/FRAME. Reset into IDLE. An accepted beat in IDLE latches mode into mode_q, copies shadow table to active table, and sets beat count to 1. It goes to FRAME unless in_last is set. An accepted beat in FRAME increments the count; an accepted in_last returns to IDLE.
- A single-beat frame (in_last on first beat) stays in IDLE, with out_len=1.
- mode changes during FRAME are ignored until the next frame start.
- Beat counter is 16 bits and saturates at 65535. out_len carries the count including the last beat.
- cfg writes always go to the shadow table and never disturb the frame in flight. A write in the same cycle as a frame-start accept is not visible to that frame.
- Reset table is identity. Duplicate src entries are legal (broadcast); no error is flagged.

## Timing
- Latency is 1 cycle: a beat accepted at edge n appears on out_* after edge n.
- in_ready = skid register empty. It is combinational from state only, never from out_ready.
- Full throughput of 1 beat/cycle with out_ready held high.
- Backpressure: when out_valid && !out_ready and a beat is accepted, the beat goes to the skid register and in_ready drops next cycle. When the output is taken, skid moves to output the same edge.
- Simultaneous accept and output drain with empty skid: the new beat goes directly to output with no bubble.
- out_valid, out_last, out_data, out_len are stable while out_valid && !out_ready.
- Reset values: out_valid 0, out_data 0, out_last 0, out_len 0, in_ready 1, FSM IDLE, count 0, both tables identity, mode_q 0.
- Reset mid-frame discards the held beats and the partial frame immediately (asynchronous). No out_last is produced for the aborted frame.

## Configuration
- TURBO_LANE_PERM_TABLE_EN defined: shadow/active tables, cfg_* ports and mode 3 exist.
- Not defined: cfg_* ports absent, no table storage, mode 3 behaves as mode 0.

## Structure
- Package turbo_perm_pkg holds:
  - mode constants PERM_IDENT, PERM_BITREV, PERM_REV, PERM_TABLE
  - a bitrev function parametrised on LW
  - the 16-bit frame length width constant
- Sub-module turbo_skid_buf holds the 2-entry output/skid register pair, parametrised on payload width (LANES*W+1+16). The top holds the FSM, counter, tables and the combinational permutation mux.

## Test plan
- LANES=4, W=30, mode 1, lane words 0x1,0x2,0x3,0x4, single-beat frame -> out lanes 0x1,0x3,0x2,0x4, out_last=1, out_len=1, one cycle after accept.
- Mode 2, 3-beat frame with out_ready=1 -> 3 consecutive output beats lanes reversed (0x4,0x3,0x2,0x1 pattern), out_last on beat 3 only, out_len=3.
- Mode 0 frame, out_ready held low 3 cycles while feeding continuously -> in_ready drops after 2 beats held, no data lost, order preserved when out_ready rises.
- Table macro on, cfg writes map {3,3,0,1}, mode 3, then rewrite mid-frame -> current frame uses {3,3,0,1}; next frame uses new map.
- mode toggled 0->2 on beat 2 of a 4-beat frame -> all 4 beats identity, next frame reversed.
- rst asserted with out_valid=1 and skid full -> out_valid=0, in_ready=1 immediately; next frame's out_len starts from 1.
